// File: rtl/multiplicador_sequencial_8bits_if.sv
// Handshake/data bundle for the sequential 8x8 multiplier.
// Optional flag wires zero/ovf are present only when MULT_FLAGS_EN is defined.
interface multiplicador_sequencial_8bits_if;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;
`ifdef MULT_FLAGS_EN
  logic        zero;
  logic        ovf;

  modport master (output start, A, B, input P, busy, done, zero, ovf);
  modport slave  (input start, A, B, output P, busy, done, zero, ovf);
`else
  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);
`endif
endinterface

// File: rtl/multiplicador_sequencial_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one
// somadorde8bits ripple adder. One iteration per cycle, 8 iterations per
// product, start/busy/done handshake.
// Optional feature macro: MULT_FLAGS_EN adds registered zero/ovf flags.

// 8-bit ripple-carry adder: the only arithmetic resource of the multiplier.
module somadorde8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] S,
  output logic       Cout
);
  localparam int unsigned W = 8;

  logic [W:0] carry;

  // Ripple the carry from bit 0 to bit 7.
  always_comb begin
    carry    = '0;
    S        = '0;
    for (int i = 0; i < int'(W); i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
    Cout = carry[W];
  end
endmodule

module multiplicador_sequencial_8bits (
  input  logic                            clk,
  input  logic                            rst_n,
  multiplicador_sequencial_8bits_if.slave bus
);
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state, state_n;
  logic [W-1:0]  m, m_n;
  logic [W-1:0]  q, q_n;
  logic [W-1:0]  acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] p, p_n;
  logic          busy, busy_n;
  logic          done, done_n;
`ifdef MULT_FLAGS_EN
  logic          zero, zero_n;
  logic          ovf, ovf_n;
`endif

  logic [W-1:0]  add_b_c;
  logic [W-1:0]  sum_c;
  logic          cout_c;

  // Partial-product operand: multiplicand when the current multiplier bit is set.
  assign add_b_c = q[0] ? m : '0;

  somadorde8bits u_adder (
    .A    (acc),
    .B    (add_b_c),
    .S    (sum_c),
    .Cout (cout_c)
  );

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MULT_FLAGS_EN
      zero  <= 1'b1;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      m     <= m_n;
      q     <= q_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      p     <= p_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef MULT_FLAGS_EN
      zero  <= zero_n;
      ovf   <= ovf_n;
`endif
    end
  end

  // Next-state and next-output logic; the carry shifts into ACC[7] so nothing is lost.
  always_comb begin
    state_n = state;
    m_n     = m;
    q_n     = q;
    acc_n   = acc;
    cnt_n   = cnt;
    p_n     = p;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef MULT_FLAGS_EN
    zero_n  = zero;
    ovf_n   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          m_n     = bus.A;
          q_n     = bus.B;
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        acc_n = {cout_c, sum_c[W-1:1]};
        q_n   = {sum_c[0], q[W-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == LAST_ITER) begin
          p_n     = {acc_n, q_n};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
`ifdef MULT_FLAGS_EN
          zero_n  = ({acc_n, q_n} == '0);
          ovf_n   = (acc_n != '0);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.P    = p;
  assign bus.busy = busy;
  assign bus.done = done;
`ifdef MULT_FLAGS_EN
  assign bus.zero = zero;
  assign bus.ovf  = ovf;
`endif
endmodule

// File: tb/tb_multiplicador_sequencial_8bits.sv
// Scoreboard bench for multiplicador_sequencial_8bits: the driver pushes the
// expected product and completion cycle; a monitor pops on every done pulse.
module tb_multiplicador_sequencial_8bits;
  logic clk = 1'b0;
  logic rst_n;

  multiplicador_sequencial_8bits_if mif ();

  multiplicador_sequencial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Edge counter used to check latency.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    return 16'(int'(a) * int'(b));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mif.done !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=%b P=%0h with nothing pending", mif.done, mif.P);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", 32'(mif.P), 32'(e.p));
        chk("latency", 32'(cyc), 32'(e.done_cyc));
`ifdef MULT_FLAGS_EN
        chk("zero_flag", 32'(mif.zero), 32'(e.p == 16'h0));
        chk("ovf_flag", 32'(mif.ovf), 32'(e.p > 16'h00FF));
`endif
      end
    end
  end

  // Called at a negedge; returns at a negedge where the DUT can accept.
  task automatic wait_idle();
    int n = 0;
    while (mif.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b still high after %0d cycles", mif.busy, n);
    end
  endtask

  // One-cycle start pulse; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    wait_idle();
    mif.A     = a;
    mif.B     = b;
    mif.start = 1'b1;
    sb.push_back('{p: ref_mul(a, b), done_cyc: cyc + 9});
    @(posedge clk);
    #1;
    chk("busy_after_start", 32'(mif.busy), 32'd1);
    mif.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_P"}, 32'(mif.P), 32'h0);
    chk({tag, "_busy"}, 32'(mif.busy), 32'd0);
    chk({tag, "_done"}, 32'(mif.done), 32'd0);
`ifdef MULT_FLAGS_EN
    chk({tag, "_zero"}, 32'(mif.zero), 32'd1);
    chk({tag, "_ovf"}, 32'(mif.ovf), 32'd0);
`endif
  endtask

  initial begin
    mif.start = 1'b0;
    mif.A     = '0;
    mif.B     = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed products from the plan.
    issue(8'd13, 8'd11);
    drain();
    issue(8'd255, 8'd255);
    drain();
    issue(8'd0, 8'd200);
    drain();
    issue(8'd1, 8'd128);
    drain();

    // start and operand changes while busy must be ignored.
    issue(8'd13, 8'd11);
    repeat (3) @(negedge clk);
    mif.start = 1'b1;
    mif.A     = 8'd2;
    mif.B     = 8'd2;
    @(negedge clk);
    mif.start = 1'b0;
    mif.A     = 8'd99;
    mif.B     = 8'd77;
    drain();
    repeat (12) @(negedge clk);

    // start held high: second operation accepted in the done cycle.
    @(negedge clk);
    wait_idle();
    mif.A     = 8'd3;
    mif.B     = 8'd5;
    mif.start = 1'b1;
    sb.push_back('{p: ref_mul(8'd3, 8'd5), done_cyc: cyc + 9});
    begin
      int n = 0;
      @(negedge clk);
      while (mif.done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_first_done_seen", 32'(mif.done), 32'd1);
    end
    mif.A = 8'd7;
    mif.B = 8'd9;
    sb.push_back('{p: ref_mul(8'd7, 8'd9), done_cyc: cyc + 9});
    @(posedge clk);
    #1;
    chk("b2b_busy_reasserted", 32'(mif.busy), 32'd1);
    mif.start = 1'b0;
    drain();

    // Reset during iteration 4 of 100*100.
    issue(8'd100, 8'd100);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check_reset_values("midreset");
    repeat (3) @(negedge clk);
    check_reset_values("midreset_hold");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", 32'(mif.P), 32'h0);
    issue(8'd100, 8'd100);
    drain();

    // Random operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      issue(8'($urandom), 8'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
